// File: rtl/hex_entry_pkg.sv
// Shared types and field positions for the two-digit hex entry block.
package hex_entry_pkg;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      HAVE_HI = 2'd1,
      HAVE_LO = 2'd2,
      FULL    = 2'd3
   } entry_state_t;

   localparam logic KEY_PRESSED = 1'b0;

   localparam int HI_MSB = 9;
   localparam int HI_LSB = 6;
   localparam int LO_MSB = 5;
   localparam int LO_LSB = 2;

endpackage

// File: rtl/key_debounce.sv
// Per-key synchronizer, debouncer and press-event detector.
// HEX_ENTRY_DEBOUNCE_EN selects full debounce; otherwise a plain synced edge.
module key_debounce
   import hex_entry_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic reset,
   input  logic key_n,
   output logic press
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);

`ifdef HEX_ENTRY_DEBOUNCE_EN
   localparam logic [CW-1:0] LIMIT = CW'(DEBOUNCE_CYCLES - 1);
`else
   localparam logic [CW-1:0] LIMIT = '0;
`endif

   logic [1:0]    sync_q, sync_d;
   logic          stable_q, stable_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          armed_q, armed_d;
   logic          press_d;

   always_comb begin
      sync_d   = {sync_q[0], key_n};
      stable_d = stable_q;
      cnt_d    = '0;
      if (sync_q[1] != stable_q) begin
         if (cnt_q == LIMIT) begin
            stable_d = sync_q[1];
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
      // a key held through reset stays silent until it is seen released
      armed_d = armed_q | (sync_q[1] != KEY_PRESSED);
      press_d = armed_q
              & (stable_q != KEY_PRESSED)
              & (stable_d == KEY_PRESSED);
   end

   always_ff @(posedge clk) begin
      sync_q <= sync_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stable_q <= ~KEY_PRESSED;
         cnt_q    <= '0;
         armed_q  <= 1'b0;
      end else begin
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         armed_q  <= armed_d;
      end
   end

   assign press = press_d;

endmodule

// File: rtl/hex_digit_entry.sv
// Two-digit hex entry from SW/KEY with per-digit valid and pair-ready pulse.
// Debounce is enabled by defining HEX_ENTRY_DEBOUNCE_EN.
module hex_digit_entry
   import hex_entry_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic [9:2] SW,
   input  logic [1:0] KEY,
   output logic [3:0] digit_hi,
   output logic [3:0] digit_lo,
   output logic       hi_valid,
   output logic       lo_valid,
   output logic       pair_ready
);

   logic hi_ev;
   logic lo_ev;

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_hi (
      .clk   (CLOCK_50),
      .reset (reset),
      .key_n (KEY[1]),
      .press (hi_ev)
   );

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_lo (
      .clk   (CLOCK_50),
      .reset (reset),
      .key_n (KEY[0]),
      .press (lo_ev)
   );

   entry_state_t state_q, state_d;
   logic [3:0]   digit_hi_q, digit_hi_d;
   logic [3:0]   digit_lo_q, digit_lo_d;
   logic         hi_valid_q, hi_valid_d;
   logic         lo_valid_q, lo_valid_d;
   logic         pair_ready_q, pair_ready_d;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         EMPTY: begin
            if (hi_ev && lo_ev) state_d = FULL;
            else if (hi_ev)     state_d = HAVE_HI;
            else if (lo_ev)     state_d = HAVE_LO;
         end
         HAVE_HI: if (lo_ev) state_d = FULL;
         HAVE_LO: if (hi_ev) state_d = FULL;
         FULL:    state_d = FULL;
      endcase

      digit_hi_d   = hi_ev ? SW[HI_MSB:HI_LSB] : digit_hi_q;
      digit_lo_d   = lo_ev ? SW[LO_MSB:LO_LSB] : digit_lo_q;
      hi_valid_d   = (state_d == HAVE_HI) || (state_d == FULL);
      lo_valid_d   = (state_d == HAVE_LO) || (state_d == FULL);
      // every load that leaves us in FULL, reloads included, re-announces the pair
      pair_ready_d = (hi_ev || lo_ev) && (state_d == FULL);
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q      <= EMPTY;
         digit_hi_q   <= '0;
         digit_lo_q   <= '0;
         hi_valid_q   <= 1'b0;
         lo_valid_q   <= 1'b0;
         pair_ready_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         digit_hi_q   <= digit_hi_d;
         digit_lo_q   <= digit_lo_d;
         hi_valid_q   <= hi_valid_d;
         lo_valid_q   <= lo_valid_d;
         pair_ready_q <= pair_ready_d;
      end
   end

   assign digit_hi   = digit_hi_q;
   assign digit_lo   = digit_lo_q;
   assign hi_valid   = hi_valid_q;
   assign lo_valid   = lo_valid_q;
   assign pair_ready = pair_ready_q;

endmodule

// File: doc/hex_digit_entry.md
# hex_digit_entry

Debounced two-digit hexadecimal entry block for the board's switch/key front panel. It produces the nibble values that the 7-segment display decoder consumes. A debounced press of KEY[1] latches SW[9:6] as the high digit, and a press of KEY[0] latches SW[5:2] as the low digit. Per-digit valid flags and a one-cycle pair-ready pulse tell downstream logic when a complete byte has been entered.

## Interface
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required to accept a key level change (10 ms at 50 MHz); minimum 2.
- CLOCK_50  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high.
- SW  input  [9:2]  switch data; [9:6] is the high nibble, [5:2] is the low nibble; asynchronous to the clock.
- KEY  input  [1:0]  pushbuttons, active-low (0 = pressed); asynchronous and bouncy.
- digit_hi  output  4  latched high nibble.
- digit_lo  output  4  latched low nibble.
- hi_valid  output  1  digit_hi has been loaded since the last reset.
- lo_valid  output  1  digit_lo has been loaded since the last reset.
- pair_ready  output  1  one-cycle pulse whenever the state becomes or remains FULL due to a load.

## Operation
- Each KEY bit passes through a 2-flop synchronizer, then a debouncer.
- Debouncer behaviour:
  - Holds a stable level, reset value 1 (released).
  - A counter increments while the synchronized input differs from the stable level; it clears to 0 whenever they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the input still differs, the stable level flips and the counter clears.
- Press event: a stable 1->0 transition, one cycle wide. Release produces no event.
- Loads:
  - A KEY[1] press event loads digit_hi <= SW[9:6].
  - A KEY[0] press event loads digit_lo <= SW[5:2].
  - SW is sampled on the same edge and is not synchronized, because SW is static during operation.
- State machine, states EMPTY, HAVE_HI, HAVE_LO, FULL:
  - EMPTY: hi press -> HAVE_HI; lo press -> HAVE_LO; both in the same cycle -> FULL.
  - HAVE_HI: lo press -> FULL; hi press -> reload digit_hi, stay in HAVE_HI.
  - HAVE_LO: hi press -> FULL; lo press -> reload digit_lo, stay in HAVE_LO.
  - FULL: any press reloads the pressed digit(s) and stays in FULL.
- hi_valid = state is HAVE_HI or FULL; lo_valid = state is HAVE_LO or FULL. Both are registered outputs.
- pair_ready is asserted for one cycle on any edge that lands in FULL because of a load, including every reload while in FULL.
- Simultaneous press events on both keys: both digits load on the same edge, and pair_ready pulses once.
- A key held down produces exactly one event. A re-press requires a debounced release first.
- Reset returns the state to EMPTY, clears the digits, and sets debouncer stable levels to 1 with counters at 0.
  - A key held through reset produces no event until it has been released and pressed again.
  - Reset mid-count discards the partial count.

## Timing
- Reset values: digit_hi=0, digit_lo=0, hi_valid=0, lo_valid=0, pair_ready=0.
- Latency from KEY going low (glitch-free) to the digit, valid flag, and pair_ready updating: 2 synchronizer cycles + DEBOUNCE_CYCLES cycles.
- Bounce: a glitch shorter than DEBOUNCE_CYCLES cycles produces no event and restarts the count.
- Outputs change only on the rising edge of CLOCK_50. There are no combinational paths from inputs to outputs.

## Configuration
- HEX_ENTRY_DEBOUNCE_EN defined: the debouncer is instantiated as described above.
- HEX_ENTRY_DEBOUNCE_EN undefined: debouncers are omitted; the press event is the synchronized 1->0 edge.
  - Latency is 2 cycles + 1 edge-detect cycle.
  - DEBOUNCE_CYCLES is ignored.
  - Intended for simulation and bounce-free sources.

## Structure
- hex_entry_pkg contains:
  - entry_state_t enum: EMPTY, HAVE_HI, HAVE_LO, FULL.
  - KEY_PRESSED = 1'b0.
  - Nibble field positions: HI_MSB=9, HI_LSB=6, LO_MSB=5, LO_LSB=2.
- One sub-module, key_debounce: synchronizer, counter, stable level, and press-event output. It is parameterized by DEBOUNCE_CYCLES and instantiated twice.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, HEX_ENTRY_DEBOUNCE_EN defined.
- Reset release -> all outputs 0; no event while KEY=2'b11 for 20 cycles.
- SW[9:6]=4'hA, KEY[1] low for 10 cycles -> digit_hi=A and hi_valid=1 exactly 6 cycles after KEY falls; pair_ready stays 0.
- Then SW[5:2]=4'h3, KEY[0] low -> digit_lo=3, lo_valid=1, pair_ready high for exactly 1 cycle.
- KEY[1] bounces low for 2 cycles, high for 1, repeated 5 times, then returns high -> no load, state unchanged.
- From EMPTY, both keys fall on the same cycle with SW=8'hF5 (bits [9:2]) -> digit_hi=F, digit_lo=5, both valid, a single pair_ready pulse.
- KEY[0] held low for 100 cycles, with reset asserted for 1 cycle mid-hold -> outputs cleared; no new event until KEY[0] is released and pressed again.
